spi_slave_regbank: RTL and testbench
====================================

// Module: spi_slave_regbank
// PURPOSE
//  Parametrised SPI mode-0 slave with a small register bank. Successor to the single-nibble shifter.
//  Decodes a command word, then writes or reads one or more DATA_W words with auto-increment.
//  Drives MISO with read data. Register contents feed the ALU/PWM datapath as a flat bus.
// PARAMETERS
//  DATA_W     8            data word width, 4..32
//  NUM_REGS   4            register count, 2..16
//  CMD_W      8            command width; [CMD_W-1]=1 write/0 read, [ADDR_W-1:0]=start address
//  RESET_VAL  0            value loaded into every register on rst
//  ADDR_W     $clog2(NUM_REGS)   derived, do not override
// PORTS
//  sclk      in   1                  SPI clock, the block's only clock; idles low between frames
//  rst       in   1                  asynchronous reset, active-low (0 = reset)
//  CS        in   1                  chip select, active-low; high asynchronously clears frame logic
//  MOSI      in   1                  serial data in, MSB first
//  MISO      out  1                  serial data out, MSB first
//  regs_o    out  NUM_REGS*DATA_W    register bank, reg k at [k*DATA_W +: DATA_W]
//  wr_addr   out  ADDR_W             address of the last committed write
//  wr_tgl    out  1                  toggles once per committed write (CDC-safe event)
//  frame_err out  1                  sticky: a frame ended mid-word
// BEHAVIOUR
//  Reset (rst=0): regs=RESET_VAL, MISO=0, wr_addr=0, wr_tgl=0, frame_err=0, FSM=IDLE, bit_cnt=0.
//  MOSI is sampled on posedge sclk. MISO changes on negedge sclk.
//  CS=1: FSM=IDLE, bit_cnt=0, tx shifter=0, MISO=0 asynchronously. regs/wr_*/frame_err hold.
//  CS rising while bit_cnt!=0, or while in CMD with bits received -> frame_err<=1.
//  FSM states: IDLE, CMD, WR, RD, DROP.
//   IDLE: first posedge with CS=0 samples command MSB -> CMD, bit_cnt=1.
//   CMD: shift CMD_W bits. On the CMD_W-th bit, latch addr and rw, and clear frame_err.
//     addr>=NUM_REGS -> DROP. Else rw=1 -> WR, or rw=0 -> RD.
//   WR: shift DATA_W bits. On the DATA_W-th posedge:
//     regs[addr]<=word, wr_addr<=addr, wr_tgl<=~wr_tgl.
//     addr <= (addr==NUM_REGS-1) ? 0 : addr+1 (wrap). Stay in WR for the next word.
//   RD: at the posedge completing CMD (or the previous RD word), load tx shifter with regs[addr].
//     On the following negedge, MISO=MSB. Shift one bit per negedge.
//     After DATA_W bits, addr increments with the same wrap rule.
//   DROP: ignore MOSI. MISO=1 for every bit. No writes. Exit only via CS=1.
//  MISO=0 throughout CMD.
//  A write becomes visible on regs_o at the committing posedge (0 latency after last bit).
//  Read of a register written earlier in the same multi-word frame returns the new value.
//  Partial word at CS rise: discarded, no register change, no wr_tgl toggle.
//  rst low mid-frame: everything returns to reset values immediately. rst has priority over CS.
//  wr_tgl is level-encoded because sclk stops after a frame. Consumers in other domains
//   sync it with 2 FFs and edge-detect.
// TESTING (DATA_W=8, NUM_REGS=4, CMD_W=8)
//  T1 reset: rst=0 then 1 -> regs_o=0, MISO=0, wr_tgl=0, frame_err=0.
//  T2 single write: CS=0, send 0x82, 0xA5, CS=1 -> reg2=0xA5, wr_addr=2, wr_tgl 0->1,
//     other regs=0.
//  T3 burst write with wrap: send 0x83, 0x11, 0x22 -> reg3=0x11, reg0=0x22, wr_tgl toggles twice.
//  T4 read back: after T2/T3, send 0x02 then 16 dummy clocks -> MISO shows 0xA5 then 0x11 MSB-first.
//     Read does not change wr_tgl.
//  T5 invalid addr: send 0x87, 0xFF -> no register change, no toggle.
//     A subsequent read 0x07 returns MISO=1 on all 8 data bits.
//  T6 abort: send 0x81, then 5 bits, CS=1 -> reg1 unchanged, frame_err=1.
//     Next valid command clears frame_err.
//     Also: rst=0 mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/spi_slave_regbank.sv
// SPI mode-0 slave with an auto-incrementing register bank.
// A command word selects read or write and a start address; data words follow until CS rises.
module spi_slave_regbank #(
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 4,
  parameter int                CMD_W     = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic                         CS,
  input  logic                         MOSI,
  output logic                         MISO,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         wr_tgl,
  output logic                         frame_err
);

  // state | meaning
  // IDLE  | waiting for the first command bit of a frame
  // CMD   | shifting in the command word, MISO held low
  // WR    | shifting in data words, each one committed to regs[addr]
  // RD    | shifting out regs[addr] on MISO, one word after another
  // DROP  | out-of-range address: ignore MOSI, drive MISO high until CS rises
  typedef enum logic [2:0] {IDLE, CMD, WR, RD, DROP} state_t;

  localparam int SH_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SH_W-2:0]     rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [CMD_W-1:0]    cmd_word;
  logic [DATA_W-1:0]   data_word;
  logic [ADDR_W-1:0]   next_addr;
  logic                cmd_done;
  logic                commit;
  logic                err_set_q;
  logic                err_clr_q;

  assign cmd_word  = {rx_q[CMD_W-2:0], MOSI};
  assign data_word = {rx_q[DATA_W-2:0], MOSI};
  assign next_addr = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 1'b1;
    rx_d      = {rx_q[SH_W-3:0], MOSI};
    tx_d      = tx_q;
    addr_d    = addr_q;
    cmd_done  = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d   = CMD;
        bit_cnt_d = CNT_W'(1);
      end
      CMD: begin
        if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
          bit_cnt_d = '0;
          cmd_done  = 1'b1;
          addr_d    = cmd_word[ADDR_W-1:0];
          // the whole field below the rw bit is range-checked, not just ADDR_W bits
          if (32'(cmd_word[CMD_W-2:0]) >= NUM_REGS) begin
            state_d = DROP;
          end else if (cmd_word[CMD_W-1]) begin
            state_d = WR;
          end else begin
            state_d = RD;
            tx_d    = regs[cmd_word[ADDR_W-1:0]];
          end
        end
      end
      WR: begin
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          commit    = 1'b1;
          addr_d    = next_addr;
        end
      end
      RD: begin
        tx_d = tx_q << 1;
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          addr_d    = next_addr;
          tx_d      = regs[next_addr];
        end
      end
      DROP: begin
        bit_cnt_d = '0;
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst or posedge CS) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
    end else if (CS) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
      wr_addr   <= '0;
      wr_tgl    <= 1'b0;
      err_clr_q <= 1'b0;
    end else begin
      if (commit) begin
        regs[addr_q] <= data_word;
        wr_addr      <= addr_q;
        wr_tgl       <= ~wr_tgl;
      end
      if (cmd_done) err_clr_q <= err_set_q;
    end
  end

  // frame_err is the XOR of a CS-edge toggle and an sclk-side acknowledge
  always_ff @(posedge CS or negedge rst) begin
    if (!rst) begin
      err_set_q <= 1'b0;
    end else if ((bit_cnt_q != '0) && !frame_err) begin
      err_set_q <= ~err_set_q;
    end
  end

  assign frame_err = err_set_q ^ err_clr_q;

  always_ff @(negedge sclk or negedge rst or posedge CS) begin
    if (!rst) begin
      MISO <= 1'b0;
    end else if (CS) begin
      MISO <= 1'b0;
    end else begin
      MISO <= (state_q == DROP) || ((state_q == RD) && tx_q[DATA_W-1]);
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Randomised self-checking bench for spi_slave_regbank against a frame-level register model.
`timescale 1ns/1ps
module tb_spi_slave_regbank;

  logic        sclk, rst, CS, MOSI;
  logic        MISO;
  logic [31:0] regs_o;
  logic [1:0]  wr_addr;
  logic        wr_tgl, frame_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_regs [4];
  logic [1:0] exp_waddr;
  logic       exp_tgl;
  logic [7:0] txb [8];
  logic [7:0] rxb [8];

  spi_slave_regbank #(.DATA_W(8), .NUM_REGS(4), .CMD_W(8), .RESET_VAL(8'h00)) dut (
    .sclk(sclk), .rst(rst), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .regs_o(regs_o), .wr_addr(wr_addr), .wr_tgl(wr_tgl), .frame_err(frame_err)
  );

  function automatic logic [31:0] model_pack();
    logic [31:0] p;
    for (int k = 0; k < 4; k++) p[k*8 +: 8] = m_regs[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;
    exp_waddr = 2'd0;
    exp_tgl   = 1'b0;
  endtask

  // applies a whole frame to the model; returns the MISO bytes expected after the command
  task automatic model_frame(input logic [7:0] cmd, input int nwords, output logic [7:0] exp_rx [8]);
    int a;
    a = int'(cmd[6:0]);
    for (int i = 0; i < 8; i++) exp_rx[i] = 8'h00;
    for (int w = 0; w < nwords; w++) begin
      if (a >= 4) begin
        exp_rx[w+1] = 8'hFF;
      end else if (cmd[7]) begin
        m_regs[a] = txb[w+1];
        exp_waddr = 2'(a);
        exp_tgl   = ~exp_tgl;
        a = (a + 1) % 4;
      end else begin
        exp_rx[w+1] = m_regs[a];
        a = (a + 1) % 4;
      end
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      #4;
      got[i] = MISO;
      sclk = 1'b1;
      #5;
      sclk = 1'b0;
      #1;
    end
  endtask

  task automatic do_frame(input int nbytes);
    CS = 1'b0;
    #5;
    for (int i = 0; i < nbytes; i++) send_bits(txb[i], 8, rxb[i]);
    #5;
    CS = 1'b1;
    #5;
  endtask

  task automatic check_state(input string name);
    checks++;
    if (regs_o !== model_pack()) begin
      failures++;
      $display("FAIL %s regs_o: got %h expected %h", name, regs_o, model_pack());
    end
    checks++;
    if (wr_addr !== exp_waddr || wr_tgl !== exp_tgl) begin
      failures++;
      $display("FAIL %s wr_addr/wr_tgl: got %0d/%0b expected %0d/%0b", name, wr_addr, wr_tgl, exp_waddr, exp_tgl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #10;
    rst = 1'b1;
    #5;
    model_reset();
    checks++;
    if (regs_o !== 32'h0 || MISO !== 1'b0 || wr_tgl !== 1'b0 || frame_err !== 1'b0 || wr_addr !== 2'd0) begin
      failures++;
      $display("FAIL reset: regs_o=%h MISO=%b wr_tgl=%b frame_err=%b wr_addr=%0d expected all zero",
               regs_o, MISO, wr_tgl, frame_err, wr_addr);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] er [8];
    txb[0] = 8'h82; txb[1] = 8'hA5;
    model_frame(txb[0], 1, er);
    do_frame(2);
    check_state("single_write");
    checks++;
    if (regs_o !== 32'h00A5_0000 || wr_tgl !== 1'b1 || wr_addr !== 2'd2) begin
      failures++;
      $display("FAIL single_write literal: regs_o=%h wr_tgl=%b wr_addr=%0d expected 00a50000/1/2", regs_o, wr_tgl, wr_addr);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] er [8];
    txb[0] = 8'h83; txb[1] = 8'h11; txb[2] = 8'h22;
    model_frame(txb[0], 2, er);
    do_frame(3);
    check_state("burst_wrap");
    checks++;
    if (regs_o !== 32'h11A5_0022 || wr_tgl !== 1'b1 || wr_addr !== 2'd0) begin
      failures++;
      $display("FAIL burst_wrap literal: regs_o=%h wr_tgl=%b wr_addr=%0d expected 11a50022/1/0", regs_o, wr_tgl, wr_addr);
    end
  endtask

  task automatic test_read_back();
    logic [7:0] er [8];
    txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h00;
    model_frame(txb[0], 2, er);
    do_frame(3);
    checks++;
    if (rxb[1] !== 8'hA5 || rxb[2] !== 8'h11) begin
      failures++;
      $display("FAIL read_back MISO: got %h %h expected a5 11", rxb[1], rxb[2]);
    end
    checks++;
    if (rxb[0] !== 8'h00) begin
      failures++;
      $display("FAIL read_back cmd MISO: got %h expected 00", rxb[0]);
    end
    check_state("read_back");
  endtask

  task automatic test_invalid_addr();
    logic [7:0] er [8];
    txb[0] = 8'h87; txb[1] = 8'hFF;
    model_frame(txb[0], 1, er);
    do_frame(2);
    check_state("invalid_write");
    txb[0] = 8'h07; txb[1] = 8'h00;
    model_frame(txb[0], 1, er);
    do_frame(2);
    checks++;
    if (rxb[1] !== 8'hFF) begin
      failures++;
      $display("FAIL invalid_read MISO: got %h expected ff", rxb[1]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    logic [7:0] er [8];
    CS = 1'b0;
    #5;
    send_bits(8'h81, 8, got);
    send_bits(8'h5A, 5, got);
    #5;
    CS = 1'b1;
    #5;
    check_state("abort");
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL abort frame_err: got %b expected 1", frame_err);
    end
    txb[0] = 8'h01; txb[1] = 8'h00;
    model_frame(txb[0], 1, er);
    do_frame(2);
    checks++;
    if (frame_err !== 1'b0 || rxb[1] !== er[1]) begin
      failures++;
      $display("FAIL abort_recover: frame_err=%b rd=%h expected 0 %h", frame_err, rxb[1], er[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] er [8];
    int nw;
    for (int f = 0; f < 30; f++) begin
      txb[0] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7))};
      nw = $urandom_range(1, 5);
      for (int i = 1; i <= nw; i++) txb[i] = 8'($urandom);
      model_frame(txb[0], nw, er);
      do_frame(nw + 1);
      for (int i = 0; i <= nw; i++) begin
        checks++;
        if (rxb[i] !== er[i]) begin
          failures++;
          $display("FAIL random f%0d cmd=%h byte%0d MISO: got %h expected %h", f, txb[0], i, rxb[i], er[i]);
        end
      end
      check_state("random");
      checks++;
      if (frame_err !== 1'b0) begin
        failures++;
        $display("FAIL random f%0d frame_err: got %b expected 0", f, frame_err);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [7:0] got;
    logic [7:0] er [8];
    CS = 1'b0;
    #5;
    send_bits(8'h02, 8, got);
    send_bits(8'h00, 3, got);
    rst = 1'b0;
    #2;
    model_reset();
    checks++;
    if (regs_o !== 32'h0 || MISO !== 1'b0 || wr_tgl !== 1'b0 || frame_err !== 1'b0 || wr_addr !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid_frame: regs_o=%h MISO=%b wr_tgl=%b frame_err=%b wr_addr=%0d expected all zero",
               regs_o, MISO, wr_tgl, frame_err, wr_addr);
    end
    CS = 1'b1;
    #5;
    rst = 1'b1;
    #5;
    txb[0] = 8'h81; txb[1] = 8'h3C;
    model_frame(txb[0], 1, er);
    do_frame(2);
    check_state("after_rst");
  endtask

  initial begin
    sclk = 1'b0;
    CS   = 1'b1;
    MOSI = 1'b0;
    rst  = 1'b0;
    model_reset();
    #3;
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_read_back();
    test_invalid_addr();
    test_abort();
    test_random();
    test_rst_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
